// File: rtl/program_counter.sv
// Program counter: 12-bit instruction address register that either steps by
// one or loads a branch target. Optional build macro PC_LINK_EN adds link_addr.
module program_counter #(
    parameter int ADDR_W     = 12,
    parameter int RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        jump_control,
    input  logic              eq_flag,
    input  logic [ADDR_W-1:0] load_data,
    input  logic              roll_over,
    output logic [ADDR_W-1:0] addr_out
`ifdef PC_LINK_EN
    ,
    output logic [ADDR_W-1:0] link_addr
`endif
);

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_ADDR);

    typedef enum logic [1:0] {
        JC_SEQ  = 2'b00,
        JC_JUMP = 2'b01,
        JC_BEQ  = 2'b10,
        JC_BNE  = 2'b11
    } jump_code_e;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic              take_jump;

    // Decode the jump code; a loop roll-over overrides every kind of jump.
    always_comb begin
        take_jump = 1'b0;
        case (jump_code_e'(jump_control))
            JC_SEQ:  take_jump = 1'b0;
            JC_JUMP: take_jump = 1'b1;
            JC_BEQ:  take_jump = eq_flag;
            JC_BNE:  take_jump = ~eq_flag;
            default: take_jump = 1'b0;
        endcase
        if (roll_over) begin
            take_jump = 1'b0;
        end
    end

    always_comb begin
        pc_inc = pc_q + ADDR_W'(1);
        pc_d   = take_jump ? load_data : pc_inc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign addr_out = pc_q;

`ifdef PC_LINK_EN
    logic [ADDR_W-1:0] link_q;
    logic [ADDR_W-1:0] link_d;

    // Return address captures the sequential successor of the jumping pc.
    always_comb begin
        link_d = take_jump ? pc_inc : link_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            link_q <= '0;
        end else begin
            link_q <= link_d;
        end
    end

    assign link_addr = link_q;
`endif

endmodule

// File: tb/tb_program_counter.sv
// Testbench for program_counter: directed test-plan steps followed by random
// cycles, each checked against a behavioural model of the next-address rules.
module tb_program_counter;

    localparam int ADDR_W = 12;
    localparam int MOD    = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic [1:0]        jump_control;
    logic              eq_flag;
    logic [ADDR_W-1:0] load_data;
    logic              roll_over;
    logic [ADDR_W-1:0] addr_out;
`ifdef PC_LINK_EN
    logic [ADDR_W-1:0] link_addr;
`endif

    int checks;
    int errors;
    int model_pc;
    int model_link;

    program_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_ADDR(0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .jump_control(jump_control),
        .eq_flag     (eq_flag),
        .load_data   (load_data),
        .roll_over   (roll_over),
        .addr_out    (addr_out)
`ifdef PC_LINK_EN
        ,
        .link_addr   (link_addr)
`endif
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: does this cycle's input combination redirect the pc?
    function automatic bit jumps(int code, bit eq, bit ro);
        if (ro) return 1'b0;
        if (code == 0) return 1'b0;
        if (code == 1) return 1'b1;
        if (code == 2) return eq;
        return !eq;
    endfunction

    // Drive one cycle of inputs, let one rising edge pass, advance the model, check.
    task automatic step(input string tag, input bit rst_n, input int code,
                        input bit eq, input int ld, input bit ro);
        rst          = rst_n;
        jump_control = code[1:0];
        eq_flag      = eq;
        load_data    = ld[ADDR_W-1:0];
        roll_over    = ro;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_pc   = 0;
            model_link = 0;
        end else if (jumps(code, eq, ro)) begin
            model_link = (model_pc + 1) % MOD;
            model_pc   = ld % MOD;
        end else begin
            model_pc = (model_pc + 1) % MOD;
        end
        checks++;
        assert (addr_out === ADDR_W'(model_pc)) else begin
            errors++;
            $error("FAIL %s: addr_out=%0h expected=%0h", tag, addr_out, model_pc);
        end
`ifdef PC_LINK_EN
        checks++;
        assert (link_addr === ADDR_W'(model_link)) else begin
            errors++;
            $error("FAIL %s_link: link_addr=%0h expected=%0h", tag, link_addr, model_link);
        end
`endif
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        model_pc     = 0;
        model_link   = 0;
        rst          = 1'b0;
        jump_control = 2'b00;
        eq_flag      = 1'b0;
        load_data    = '0;
        roll_over    = 1'b0;

        // Reset wins over a pending unconditional jump
        step("reset", 1'b0, 1, 1'b0, 45, 1'b0);
        step("seq1", 1'b1, 0, 1'b0, 45, 1'b0);
        step("seq2", 1'b1, 0, 1'b0, 45, 1'b0);
        step("seq3", 1'b1, 0, 1'b0, 45, 1'b0);

        // Unconditional jump, held for three cycles
        for (int i = 0; i < 3; i++) step("jump_hold", 1'b1, 1, 1'b0, 45, 1'b0);

        // Branch if equal: taken twice, then not taken
        step("beq_taken", 1'b1, 2, 1'b1, 4, 1'b0);
        step("beq_stay", 1'b1, 2, 1'b1, 4, 1'b0);
        step("beq_not", 1'b1, 2, 1'b0, 4, 1'b0);

        // Branch if not equal, then sequential run
        step("bne_taken", 1'b1, 3, 1'b0, 45, 1'b0);
        for (int i = 0; i < 5; i++) step("seq_run", 1'b1, 0, 1'b0, 45, 1'b0);
        step("bne_not", 1'b1, 3, 1'b1, 45, 1'b0);

        // Roll-over suppresses the jump, releasing it lets the jump through
        step("goto10", 1'b1, 1, 1'b0, 10, 1'b0);
        step("rollover", 1'b1, 1, 1'b0, 45, 1'b1);
        step("rollover_beq", 1'b1, 2, 1'b1, 45, 1'b1);
        step("roll_release", 1'b1, 1, 1'b0, 45, 1'b0);

        // Wrap-around through 0xFFF
        step("wrap_jump", 1'b1, 1, 1'b0, 'hFFE, 1'b0);
        step("wrap_fff", 1'b1, 0, 1'b0, 0, 1'b0);
        step("wrap_000", 1'b1, 0, 1'b0, 0, 1'b0);
        step("wrap_001", 1'b1, 0, 1'b0, 0, 1'b0);
        step("jump_to_fff", 1'b1, 1, 1'b0, 'hFFF, 1'b0);
        step("jump_from_fff", 1'b1, 1, 1'b0, 'h123, 1'b0);

        // Mid-sequence reset drops the jump; first cycle after release is evaluated normally
        step("mid_reset", 1'b0, 1, 1'b0, 77, 1'b0);
        step("post_reset_jump", 1'b1, 1, 1'b0, 7, 1'b0);

        // Random cycles with occasional resets
        for (int i = 0; i < 400; i++) begin
            step("random", ($urandom_range(0, 31) != 0), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), $urandom_range(0, MOD - 1),
                 ($urandom_range(0, 5) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- 12-bit instruction-address register for the sequencer/controller datapath.
- Each clock it either advances by one or loads a branch target from load_data.
- The load decision comes from a 2-bit jump code, the comparator equality flag, and a loop roll-over qualifier.
- addr_out drives the instruction memory address.

Parameters:
- ADDR_W, 12, width of addr_out and load_data.
- RESET_ADDR, 0, value loaded into addr_out on reset; truncated to ADDR_W bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-low reset; sampled only on rising clk.
- jump_control  input  2  next-address select code (see Behaviour).
- eq_flag  input  1  comparator equality result, used by conditional branches.
- load_data  input  ADDR_W  branch target address.
- roll_over  input  1  loop-counter roll-over; when high, all jumps are suppressed.
- addr_out  output  ADDR_W  current program counter, registered.

Behaviour:
- Single register pc drives addr_out directly; no combinational path from inputs to addr_out.
- Reset: on a rising clk with rst==0, pc <= RESET_ADDR (0x000).
  - Reset has highest priority, regardless of the other inputs.
  - Asynchronous assertion has no effect until the next edge.
- Otherwise, on each rising clk, compute take_jump:
  - 2'b00: take_jump = 0 (sequential).
  - 2'b01: take_jump = 1 (unconditional jump).
  - 2'b10: take_jump = eq_flag (branch if equal).
  - 2'b11: take_jump = ~eq_flag (branch if not equal).
  - If roll_over==1, take_jump is forced to 0.
- Next state:
  - take_jump==1: pc <= load_data.
  - take_jump==0: pc <= pc + 1, modulo 2^ADDR_W.
- Wrap-around: 0xFFF + 1 -> 0x000; no flag, no stall.
- A held unconditional jump reloads the same target every cycle, so pc stays constant.
- No pipeline; latency is 1 cycle from input sampling to addr_out.
- Inputs are sampled only at the clock edge; glitches between edges are ignored.
- Reset mid-sequence discards the pending jump; the first cycle after release starts from RESET_ADDR and evaluates the inputs normally.

Optional Feature:
- Macro: PC_LINK_EN.
- Defined:
  - Adds output link_addr [ADDR_W-1:0], registered.
  - On every cycle where take_jump==1, link_addr <= pc + 1 (return address, wraps modulo 2^ADDR_W).
  - Otherwise link_addr holds its value.
  - Reset sets link_addr to 0.
- Not defined: port absent, no extra logic; program counter behaviour is identical in both builds.

Test Plan:
- Reset: rst=0 for 1 cycle with jump_control=01, load_data=45 -> addr_out=0. After release with jump_control=00 -> 1, 2, 3 on successive edges.
- Unconditional jump: jump_control=01, load_data=45, eq_flag=0 -> addr_out=45, held at 45 for 3 consecutive cycles.
- Branch-if-equal:
  - jump_control=10, load_data=4, eq_flag=1 -> addr_out=4 and stays 4.
  - Same code with eq_flag=0, starting from pc=4 -> 5.
- Branch-if-not-equal, then sequential:
  - jump_control=11, eq_flag=0, load_data=45 -> 45.
  - Then jump_control=00 -> 46, 47, 48, 49, 50.
- Roll-over suppression: roll_over=1, jump_control=01, load_data=45, pc=10 -> 11. Deassert roll_over -> 45 next edge.
- Wrap: jump_control=01, load_data=0xFFE, then jump_control=00 -> 0xFFE, 0xFFF, 0x000, 0x001. With PC_LINK_EN, link_addr after the jump equals the pre-jump pc+1.
